// File: rtl/rvm_mem_arbiter_if.sv
// rvm_mem_arbiter_if
// Bundles the two requester ports and the shared SRAM bus of the memory
// arbiter.
//
// Handshake: a requester raises mN_req with a non-zero mN_ben. It holds
// addr/wdata/ben/wen stable until mN_done pulses for one cycle. mN_error
// and the read data in mN_rdata are valid with that pulse. In the cycle
// after done, the requester either drops req or presents its next request.
//
// Signals:
//   m0_* / m1_* : requester ports (req, addr, wdata, ben, wen in; rdata,
//                 done, error out of the arbiter).
//   mem_*       : shared SRAM bus (addr, wdata, ben, wen out of the arbiter;
//                 rdata, stall, error into it). mem_ben == 0 means idle.
// Modports:
//   slave  - arbiter side
//   master - requesters plus memory, the opposite direction
interface rvm_mem_arbiter_if;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_ben;
  logic        m0_wen;
  logic [31:0] m0_rdata;
  logic        m0_done;
  logic        m0_error;

  logic        m1_req;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_ben;
  logic        m1_wen;
  logic [31:0] m1_rdata;
  logic        m1_done;
  logic        m1_error;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_ben;
  logic        mem_wen;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        mem_error;

  modport slave (
    input  m0_req, m0_addr, m0_wdata, m0_ben, m0_wen,
    output m0_rdata, m0_done, m0_error,
    input  m1_req, m1_addr, m1_wdata, m1_ben, m1_wen,
    output m1_rdata, m1_done, m1_error,
    output mem_addr, mem_wdata, mem_ben, mem_wen,
    input  mem_rdata, mem_stall, mem_error
  );

  modport master (
    output m0_req, m0_addr, m0_wdata, m0_ben, m0_wen,
    input  m0_rdata, m0_done, m0_error,
    output m1_req, m1_addr, m1_wdata, m1_ben, m1_wen,
    input  m1_rdata, m1_done, m1_error,
    input  mem_addr, mem_wdata, mem_ben, mem_wen,
    output mem_rdata, mem_stall, mem_error
  );
endinterface

// File: rtl/rvm_mem_arbiter.sv
// rvm_mem_arbiter
// Shares the single SRAM bus between the core port (m0) and the
// debug/loader port (m1). The arbiter runs one transaction at a time:
//   IDLE -> BUSYn (bus driven from port n) -> DONEn (one-cycle done) -> IDLE
// A stall watchdog ends a transaction with an error after STALL_LIMIT
// consecutive stalled cycles. Setting STALL_LIMIT to 0 disables it.
//
// Ports:
//   clk       - clock, rising edge
//   reset     - synchronous, active-high
//   bus       - rvm_mem_arbiter_if.slave (requester ports + shared SRAM bus)
//   dbg_state - current FSM state (0 IDLE, 1 BUSY0, 2 BUSY1, 3 DONE0, 4 DONE1)
//
// Build option:
//   RVM_ARB_RR_EN - when defined, simultaneous requests are served round-robin.
//                   When undefined, port 0 always wins.
module rvm_mem_arbiter #(
  parameter int STALL_LIMIT = 255,
  parameter int STALL_CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  rvm_mem_arbiter_if.slave bus,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BUSY0 = 3'd1,
    BUSY1 = 3'd2,
    DONE0 = 3'd3,
    DONE1 = 3'd4
  } state_t;

  localparam logic [STALL_CNT_W-1:0] LIMIT = STALL_CNT_W'(STALL_LIMIT);
  localparam bit WDOG_EN = (STALL_LIMIT != 0);

  state_t                 state_q, state_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0]            rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                   err0_q, err0_d, err1_q, err1_d;
  logic                   req0_v, req1_v, grant1, timeout;

  // A request with no byte enables would look like an idle bus, so it is
  // not treated as a request.
  assign req0_v = bus.m0_req && (bus.m0_ben != 4'h0);
  assign req1_v = bus.m1_req && (bus.m1_ben != 4'h0);

`ifdef RVM_ARB_RR_EN
  // rr_q holds the port preferred on a tie. After reset it is port 0. When a
  // transaction completes, it flips to the port that was not just served.
  logic rr_q, rr_d;

  assign grant1 = req1_v && (!req0_v || rr_q);

  always_comb begin
    rr_d = rr_q;
    if (state_q == BUSY0 && state_d == DONE0) rr_d = 1'b1;
    if (state_q == BUSY1 && state_d == DONE1) rr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) rr_q <= 1'b0;
    else       rr_q <= rr_d;
  end
`else
  assign grant1 = req1_v && !req0_v;
`endif

  // Shared bus is driven only while a port owns it.
  always_comb begin
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    bus.mem_ben   = 4'h0;
    bus.mem_wen   = 1'b0;
    if (state_q == BUSY0) begin
      bus.mem_addr  = bus.m0_addr;
      bus.mem_wdata = bus.m0_wdata;
      bus.mem_ben   = bus.m0_ben;
      bus.mem_wen   = bus.m0_wen;
    end else if (state_q == BUSY1) begin
      bus.mem_addr  = bus.m1_addr;
      bus.mem_wdata = bus.m1_wdata;
      bus.mem_ben   = bus.m1_ben;
      bus.mem_wen   = bus.m1_wen;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    err0_d   = err0_q;
    err1_d   = err1_q;
    // The stall counter saturates. The watchdog fires on the stalled cycle
    // that brings the count to the limit.
    cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + STALL_CNT_W'(1);
    timeout  = WDOG_EN && (cnt_inc == LIMIT);
    unique case (state_q)
      IDLE: begin
        if (req0_v || req1_v) state_d = grant1 ? BUSY1 : BUSY0;
      end
      BUSY0: begin
        if (!bus.mem_stall) begin
          state_d = DONE0;
          cnt_d   = '0;
          err0_d  = bus.mem_error;
          if (!bus.m0_wen) rdata0_d = bus.mem_rdata;
        end else if (timeout) begin
          state_d = DONE0;
          cnt_d   = '0;
          err0_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      BUSY1: begin
        if (!bus.mem_stall) begin
          state_d = DONE1;
          cnt_d   = '0;
          err1_d  = bus.mem_error;
          if (!bus.m1_wen) rdata1_d = bus.mem_rdata;
        end else if (timeout) begin
          state_d = DONE1;
          cnt_d   = '0;
          err1_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DONE0: begin
        state_d = IDLE;
        err0_d  = 1'b0;
      end
      DONE1: begin
        state_d = IDLE;
        err1_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rdata0_q <= 32'h0;
      rdata1_q <= 32'h0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
    end
  end

  // The error registers are only ever set on entry to DONEn and are cleared
  // on leaving it, so they can drive the outputs directly.
  assign bus.m0_done  = (state_q == DONE0);
  assign bus.m1_done  = (state_q == DONE1);
  assign bus.m0_error = err0_q;
  assign bus.m1_error = err1_q;
  assign bus.m0_rdata = rdata0_q;
  assign bus.m1_rdata = rdata1_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_rvm_mem_arbiter.sv
module tb_rvm_mem_arbiter;

  localparam logic [2:0] S_I  = 3'd0;
  localparam logic [2:0] S_B0 = 3'd1;
  localparam logic [2:0] S_B1 = 3'd2;
  localparam logic [2:0] S_D0 = 3'd3;
  localparam logic [2:0] S_D1 = 3'd4;

  localparam logic [31:0] M0_ADDR  = 32'h0000_0010;
  localparam logic [31:0] M0_WDATA = 32'hAAAA_5555;
  localparam logic [31:0] M1_ADDR  = 32'h0000_0100;
  localparam logic [31:0] M1_WDATA = 32'h1234_5678;

`ifdef RVM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam logic [31:0] RD  = 32'hDEAD_BEEF;
  localparam logic [31:0] R11 = 32'h1111_1111;
  localparam logic [31:0] R22 = 32'h2222_2222;
  localparam logic [31:0] R3  = 32'h3333_3333;
  // Read data held by each port after the two back-to-back simultaneous requests.
  localparam logic [31:0] R0C = RR ? R11 : R22;
  localparam logic [31:0] R1C = RR ? R22 : 32'h0;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  rvm_mem_arbiter_if bus();

  rvm_mem_arbiter #(
    .STALL_LIMIT(4),
    .STALL_CNT_W(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // ---------------- vectors ----------------
  typedef struct {
    logic        rst;
    logic        q0;
    logic [3:0]  b0;
    logic        q1;
    logic        w1;
    logic        stall;
    logic        merr;
    logic [31:0] rdata;
    logic [2:0]  e_st;
    logic [3:0]  e_ben;
    logic        e_wen;
    logic        e_d0;
    logic        e_e0;
    logic [31:0] e_r0;
    logic        e_d1;
    logic        e_e1;
    logic [31:0] e_r1;
  } vec_t;

  function automatic vec_t mk(
    input logic rst, input logic q0, input logic [3:0] b0, input logic q1,
    input logic w1, input logic stall, input logic merr, input logic [31:0] rdata,
    input logic [2:0] e_st, input logic [3:0] e_ben, input logic e_wen,
    input logic e_d0, input logic e_e0, input logic [31:0] e_r0,
    input logic e_d1, input logic e_e1, input logic [31:0] e_r1);
    vec_t v;
    v.rst = rst; v.q0 = q0; v.b0 = b0; v.q1 = q1; v.w1 = w1;
    v.stall = stall; v.merr = merr; v.rdata = rdata;
    v.e_st = e_st; v.e_ben = e_ben; v.e_wen = e_wen;
    v.e_d0 = e_d0; v.e_e0 = e_e0; v.e_r0 = e_r0;
    v.e_d1 = e_d1; v.e_e1 = e_e1; v.e_r1 = e_r1;
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs after the falling edge, then compare the
  // outputs that result from the current state and those inputs.
  task automatic step(input vec_t v, input string tag);
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    @(negedge clk);
    reset         = v.rst;
    bus.m0_req    = v.q0;
    bus.m0_ben    = v.b0;
    bus.m1_req    = v.q1;
    bus.m1_wen    = v.w1;
    bus.mem_stall = v.stall;
    bus.mem_error = v.merr;
    bus.mem_rdata = v.rdata;
    #1;
    e_addr  = (v.e_st == S_B0) ? M0_ADDR  : (v.e_st == S_B1) ? M1_ADDR  : 32'h0;
    e_wdata = (v.e_st == S_B0) ? M0_WDATA : (v.e_st == S_B1) ? M1_WDATA : 32'h0;
    chk({tag, ".state"},    32'(dbg_state),    32'(v.e_st));
    chk({tag, ".mem_ben"},  32'(bus.mem_ben),  32'(v.e_ben));
    chk({tag, ".mem_wen"},  32'(bus.mem_wen),  32'(v.e_wen));
    chk({tag, ".mem_addr"}, bus.mem_addr,      e_addr);
    chk({tag, ".mem_wdata"}, bus.mem_wdata,    e_wdata);
    chk({tag, ".m0_done"},  32'(bus.m0_done),  32'(v.e_d0));
    chk({tag, ".m0_error"}, 32'(bus.m0_error), 32'(v.e_e0));
    chk({tag, ".m0_rdata"}, bus.m0_rdata,      v.e_r0);
    chk({tag, ".m1_done"},  32'(bus.m1_done),  32'(v.e_d1));
    chk({tag, ".m1_error"}, 32'(bus.m1_error), 32'(v.e_e1));
    chk({tag, ".m1_rdata"}, bus.m1_rdata,      v.e_r1);
  endtask

  // ---------------- stimulus ----------------
  vec_t tbl[$];

  initial begin
    // Read: no stall, done two cycles after the request is seen.
    tbl.push_back(mk(0,1,4'hF,0,0,0,0,32'h0,          S_I, 4'h0,0, 0,0,32'h0, 0,0,32'h0));
    tbl.push_back(mk(0,1,4'hF,0,0,0,0,RD,             S_B0,4'hF,0, 0,0,32'h0, 0,0,32'h0));
    tbl.push_back(mk(0,0,4'hF,0,0,0,0,32'h0,          S_D0,4'h0,0, 1,0,RD,    0,0,32'h0));
    tbl.push_back(mk(0,0,4'hF,0,0,0,0,32'h0,          S_I, 4'h0,0, 0,0,RD,    0,0,32'h0));
    // Port 1 write with three stall cycles. Write data must not be captured.
    tbl.push_back(mk(0,0,4'hF,1,1,0,0,32'h0,          S_I, 4'h0,0, 0,0,RD, 0,0,32'h0));
    tbl.push_back(mk(0,0,4'hF,1,1,1,0,32'h0,          S_B1,4'h3,1, 0,0,RD, 0,0,32'h0));
    tbl.push_back(mk(0,0,4'hF,1,1,1,0,32'h0,          S_B1,4'h3,1, 0,0,RD, 0,0,32'h0));
    tbl.push_back(mk(0,0,4'hF,1,1,1,0,32'h0,          S_B1,4'h3,1, 0,0,RD, 0,0,32'h0));
    tbl.push_back(mk(0,0,4'hF,1,1,0,0,32'hCAFE_F00D,  S_B1,4'h3,1, 0,0,RD, 0,0,32'h0));
    tbl.push_back(mk(0,0,4'hF,1,1,0,0,32'h0,          S_D1,4'h0,0, 0,0,RD, 1,0,32'h0));
    tbl.push_back(mk(0,0,4'hF,0,0,0,0,32'h0,          S_I, 4'h0,0, 0,0,RD, 0,0,32'h0));
    // Simultaneous requests, twice in succession.
    tbl.push_back(mk(0,1,4'hF,1,0,0,0,32'h0,          S_I, 4'h0,0, 0,0,RD,  0,0,32'h0));
    tbl.push_back(mk(0,1,4'hF,1,0,0,0,R11,            S_B0,4'hF,0, 0,0,RD,  0,0,32'h0));
    tbl.push_back(mk(0,1,4'hF,1,0,0,0,32'h0,          S_D0,4'h0,0, 1,0,R11, 0,0,32'h0));
    tbl.push_back(mk(0,1,4'hF,1,0,0,0,32'h0,          S_I, 4'h0,0, 0,0,R11, 0,0,32'h0));
    tbl.push_back(mk(0,1,4'hF,1,0,0,0,R22,            RR ? S_B1 : S_B0, RR ? 4'h3 : 4'hF, 0,
                     0,0,R11, 0,0,32'h0));
    tbl.push_back(mk(0,0,4'hF,0,0,0,0,32'h0,          RR ? S_D1 : S_D0, 4'h0, 0,
                     !RR, 0, R0C, RR, 0, R1C));
    tbl.push_back(mk(0,0,4'hF,0,0,0,0,32'h0,          S_I, 4'h0,0, 0,0,R0C, 0,0,R1C));
    // Port 1 read that returns a memory error; the error lasts one cycle.
    tbl.push_back(mk(0,0,4'hF,1,0,0,0,32'h0,          S_I, 4'h0,0, 0,0,R0C, 0,0,R1C));
    tbl.push_back(mk(0,0,4'hF,1,0,0,1,R3,             S_B1,4'h3,0, 0,0,R0C, 0,0,R1C));
    tbl.push_back(mk(0,0,4'hF,0,0,0,0,32'h0,          S_D1,4'h0,0, 0,0,R0C, 1,1,R3));
    tbl.push_back(mk(0,0,4'hF,0,0,0,0,32'h0,          S_I, 4'h0,0, 0,0,R0C, 0,0,R3));
    // A request with zero byte enables is not granted.
    tbl.push_back(mk(0,1,4'h0,0,0,0,0,32'h0,          S_I, 4'h0,0, 0,0,R0C, 0,0,R3));
    tbl.push_back(mk(0,1,4'h0,0,0,0,0,32'h0,          S_I, 4'h0,0, 0,0,R0C, 0,0,R3));

    reset         = 1'b1;
    bus.m0_req    = 1'b0;
    bus.m0_addr   = M0_ADDR;
    bus.m0_wdata  = M0_WDATA;
    bus.m0_ben    = 4'hF;
    bus.m0_wen    = 1'b0;
    bus.m1_req    = 1'b0;
    bus.m1_addr   = M1_ADDR;
    bus.m1_wdata  = M1_WDATA;
    bus.m1_ben    = 4'h3;
    bus.m1_wen    = 1'b0;
    bus.mem_rdata = 32'h0;
    bus.mem_stall = 1'b0;
    bus.mem_error = 1'b0;
    repeat (2) @(posedge clk);

    // Reset values, with requests present but reset still held.
    step(mk(1,1,4'hF,1,0,0,0,32'h0, S_I,4'h0,0, 0,0,32'h0, 0,0,32'h0), "reset");

    foreach (tbl[i]) step(tbl[i], $sformatf("row%0d", i));

    // Watchdog: four stalled BUSY cycles force an error completion.
    step(mk(0,1,4'hF,0,0,1,0,32'h0, S_I,4'h0,0, 0,0,R0C, 0,0,R3), "wd_idle");
    for (int k = 0; k < 4; k++)
      step(mk(0,1,4'hF,0,0,1,0,32'h5555_5555, S_B0,4'hF,0, 0,0,R0C, 0,0,R3),
           $sformatf("wd_busy%0d", k));
    step(mk(0,1,4'hF,0,0,1,0,32'h0, S_D0,4'h0,0, 1,1,R0C, 0,0,R3), "wd_done");
    step(mk(0,0,4'hF,0,0,0,0,32'h0, S_I, 4'h0,0, 0,0,R0C, 0,0,R3), "wd_after");

    // Reset during a stalled port-1 transaction, then a clean retry.
    step(mk(0,0,4'hF,1,0,1,0,32'h0, S_I, 4'h0,0, 0,0,R0C, 0,0,R3), "mr_idle");
    step(mk(0,0,4'hF,1,0,1,0,32'h0, S_B1,4'h3,0, 0,0,R0C, 0,0,R3), "mr_busy");
    step(mk(1,0,4'hF,1,0,1,0,32'h0, S_B1,4'h3,0, 0,0,R0C, 0,0,R3), "mr_assert");
    step(mk(0,0,4'hF,1,0,0,0,32'h0, S_I, 4'h0,0, 0,0,32'h0, 0,0,32'h0), "mr_after");
    step(mk(0,0,4'hF,1,0,0,0,32'h4444_4444, S_B1,4'h3,0, 0,0,32'h0, 0,0,32'h0), "mr_rebusy");
    step(mk(0,0,4'hF,0,0,0,0,32'h0, S_D1,4'h0,0, 0,0,32'h0, 1,0,32'h4444_4444), "mr_redone");
    step(mk(0,0,4'hF,0,0,0,0,32'h0, S_I, 4'h0,0, 0,0,32'h0, 0,0,32'h4444_4444), "mr_reidle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/rvm_mem_arbiter.md
Name: rvm_mem_arbiter

Overview:
- Shares the single SRAM memory bus (addr/rdata/wdata/b_en/w_en/stall/error) between two requesters.
  - Port 0: core load/store/fetch port.
  - Port 1: debug/loader port, used for preloading memory and reading results without the bench backdoor.
- Sits between rvm_core and sram at SoC top level.
- Sequences one transaction at a time, with a stall watchdog and registered response data.

Parameters:
- STALL_LIMIT, 255: max consecutive stalled BUSY cycles before forced error completion; 0 disables the watchdog.
- STALL_CNT_W, 8: width of the stall counter; must hold STALL_LIMIT.

Ports:
- clk  in  1  core clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- m0_req  in  1  port 0 request; addr/wdata/ben/wen held stable while high.
- m0_addr  in  32  port 0 byte address.
- m0_wdata  in  32  port 0 write data.
- m0_ben  in  4  port 0 byte enables; must be non-zero for a valid request.
- m0_wen  in  1  port 0 write enable (1 = write).
- m0_rdata  out  32  port 0 registered read data.
- m0_done  out  1  port 0 one-cycle completion pulse.
- m0_error  out  1  port 0 error, valid with m0_done.
- m1_req, m1_addr, m1_wdata, m1_ben, m1_wen, m1_rdata, m1_done, m1_error: same widths and meaning for port 1.
- mem_addr  out  32  shared bus address.
- mem_wdata  out  32  shared bus write data.
- mem_ben  out  4  shared bus byte enable; 0 = bus idle.
- mem_wen  out  1  shared bus write enable.
- mem_rdata  in  32  memory read data.
- mem_stall  in  1  memory stall.
- mem_error  in  1  memory error, sampled on the non-stalled cycle.

Behaviour:
- Reset values: state=IDLE; all mN_done=0, mN_error=0, mN_rdata=0; mem_addr=0, mem_wdata=0, mem_ben=0, mem_wen=0; stall counter=0; rr pointer=0.
- States: IDLE, BUSY0, BUSY1, DONE0, DONE1.
- IDLE:
  - mem_ben=0 and mem_wen=0.
  - Samples m0_req and m1_req and selects the winner (see priority).
  - Next state BUSYn; stays IDLE if no request.
- BUSYn:
  - mem_addr/wdata/ben/wen driven combinationally from port n.
  - If mem_stall=0: capture mem_rdata into mn_rdata (reads only; writes leave mn_rdata unchanged), capture mem_error into mn_error, go to DONEn, clear the counter.
  - If mem_stall=1: increment the stall counter.
  - If STALL_LIMIT!=0 and the counter reaches STALL_LIMIT while still stalled: go to DONEn with mn_error=1, mn_rdata unchanged.
- DONEn:
  - mn_done=1 for exactly this cycle; mem_ben=0.
  - Requests are ignored; next state is IDLE.
  - The requester must drop req or present its next request in the cycle after done.
- Latency with no stall:
  - Request seen in IDLE at cycle T.
  - Bus driven at T+1.
  - done at T+2.
  - Next arbitration at T+3.
  - Each stall cycle adds 1.
- mn_error clears to 0 in the cycle after DONEn; mn_rdata holds until the next read by port n.
- Priority without macro: fixed, port 0 wins on simultaneous requests, so port 1 can starve.
- The non-granted port's outputs stay 0 and its request remains pending.
- Reset asserted mid-transaction: next edge forces IDLE, all outputs to reset values, no done pulse.
- Stall counter saturates; it never wraps.

Optional Feature:
- RVM_ARB_RR_EN defined:
  - Round-robin arbitration using a 1-bit last-served pointer, updated on entry to DONEn.
  - On simultaneous requests, the port not last served wins; a single request always wins.
- RVM_ARB_RR_EN undefined: fixed priority, port 0 wins; the pointer logic is absent.

Test Plan:
- Reset, then m0 read addr=0x00000010 ben=0xF, memory returns 0xDEADBEEF with no stall -> mem_ben=0xF at T+1, m0_done pulse at T+2, m0_rdata=0xDEADBEEF, m0_error=0.
- m1 write addr=0x00000100 wdata=0x12345678 ben=0x3 with mem_stall high for 3 cycles -> bus held stable 4 cycles, m1_done at T+5, m0 outputs stay 0.
- m0 and m1 request together twice in succession -> without macro, both grants go to m0. With RVM_ARB_RR_EN, the order is m0 then m1.
- STALL_LIMIT=4, mem_stall held high -> done with m0_error=1 after 4 stalled BUSY cycles, m0_rdata unchanged, then IDLE.
- Reset asserted during BUSY1 with mem_stall=1 -> next cycle IDLE, mem_ben=0, no m1_done. m1 re-request after reset completes normally.
- mem_error=1 on a non-stalled cycle for m1 read -> m1_done with m1_error=1. In the next cycle m1_error=0.
